// File: rtl/sqrt_pkg.sv
// sqrt_pkg: default widths and the stage record layout shared by
// the square-root pipeline files.
package sqrt_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_TAG_W  = 4;
  localparam int DEF_ROOT_W = DEF_DATA_W / 2;

  // One pipeline slot at the default widths.
  typedef struct packed {
    logic                  vld;
    logic [DEF_ROOT_W+1:0] rem;
    logic [DEF_ROOT_W-1:0] root;
    logic [DEF_DATA_W-1:0] rad;
    logic [DEF_TAG_W-1:0]  tag;
  } stage_t;

endpackage

// File: rtl/sqrt_pipe_if.sv
// sqrt_pipe_if: operand/result handshake bundle of the
// square-root pipeline.
interface sqrt_pipe_if #(
  parameter int DATA_W = sqrt_pkg::DEF_DATA_W,
  parameter int TAG_W  = sqrt_pkg::DEF_TAG_W
);

  localparam int ROOT_W = DATA_W / 2;

  logic              in_vld;
  logic              in_rdy;
  logic [DATA_W-1:0] in_x;
  logic [TAG_W-1:0]  in_tag;
  logic              out_vld;
  logic              out_rdy;
  logic [ROOT_W-1:0] out_y;
  logic [ROOT_W:0]   out_rem;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_vld, in_x, in_tag, out_rdy,
    input  in_rdy, out_vld, out_y, out_rem, out_tag
  );

  modport slave (
    input  in_vld, in_x, in_tag, out_rdy,
    output in_rdy, out_vld, out_y, out_rem, out_tag
  );

endinterface

// File: rtl/sqrt_stage.sv
// sqrt_stage: one restoring trial-subtract producing one root bit,
// followed by the slot registers.
module sqrt_stage
  import sqrt_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int TAG_W    = DEF_TAG_W,
  parameter bit KEEP_REM = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                adv,
  input  logic                prev_vld,
  input  logic [DATA_W/2+1:0] prev_rem,
  input  logic [DATA_W/2-1:0] prev_root,
  input  logic [DATA_W-1:0]   prev_rad,
  input  logic [TAG_W-1:0]    prev_tag,
  output logic                vld,
  output logic [DATA_W/2+1:0] rem,
  output logic [DATA_W/2-1:0] root,
  output logic [DATA_W-1:0]   rad,
  output logic [TAG_W-1:0]    tag
);

  localparam int ROOT_W = DATA_W / 2;

  logic [ROOT_W+3:0] cand;
  logic [ROOT_W+3:0] trial;
  logic [ROOT_W+1:0] diff;
  logic [ROOT_W+1:0] nxt_rem;
  logic              ge;

  // Bring down the next two radicand bits, try 4*root+1.
  always_comb begin
    cand    = {prev_rem, prev_rad[DATA_W-1 -: 2]};
    trial   = {2'b00, prev_root, 2'b01};
    diff    = cand[ROOT_W+1:0] - trial[ROOT_W+1:0];
    ge      = cand >= trial;
    nxt_rem = ge ? diff : cand[ROOT_W+1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld  <= 1'b0;
      root <= '0;
      rad  <= '0;
      tag  <= '0;
    end else if (adv) begin
      vld  <= prev_vld;
      root <= {prev_root[ROOT_W-2:0], ge};
      rad  <= {prev_rad[DATA_W-3:0], 2'b00};
      tag  <= prev_tag;
    end
  end

  generate
    if (KEEP_REM) begin : g_rem
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          rem <= '0;
        else if (adv)
          rem <= nxt_rem;
      end
    end else begin : g_no_rem
      assign rem = '0;
    end
  endgenerate

endmodule

// File: rtl/sqrt_pipe.sv
// sqrt_pipe: ROOT_W-stage integer square root with tag and stall.
// Define SQRT_PIPE_REM_EN to build the remainder output.
module sqrt_pipe
  import sqrt_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic       clk,
  input  logic       rst,
  sqrt_pipe_if.slave bus,
  output logic       busy
);

  localparam int ROOT_W = DATA_W / 2;

  logic              adv;
  logic [ROOT_W:0]   vld;
  logic [ROOT_W+1:0] rem  [ROOT_W+1];
  logic [ROOT_W-1:0] root [ROOT_W+1];
  logic [DATA_W-1:0] rad  [ROOT_W+1];
  logic [TAG_W-1:0]  tag  [ROOT_W+1];

  // Whole pipe moves as one; a stalled head freezes every slot.
  assign adv        = !vld[ROOT_W] | bus.out_rdy;
  assign bus.in_rdy = adv;

  assign vld[0]  = bus.in_vld;
  assign rem[0]  = '0;
  assign root[0] = '0;
  assign rad[0]  = bus.in_x;
  assign tag[0]  = bus.in_tag;

  assign bus.out_vld = vld[ROOT_W];
  assign bus.out_y   = root[ROOT_W];
  assign bus.out_tag = tag[ROOT_W];
  assign busy        = |vld[ROOT_W:1];

`ifdef SQRT_PIPE_REM_EN
  localparam bit REM_ALL = 1'b1;
  assign bus.out_rem = rem[ROOT_W][ROOT_W:0];
`else
  localparam bit REM_ALL = 1'b0;
  assign bus.out_rem = '0;
`endif

  generate
    for (genvar k = 0; k < ROOT_W; k++) begin : g_stage
      sqrt_stage #(
        .DATA_W   (DATA_W),
        .TAG_W    (TAG_W),
        .KEEP_REM (REM_ALL || (k != ROOT_W - 1))
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .adv       (adv),
        .prev_vld  (vld[k]),
        .prev_rem  (rem[k]),
        .prev_root (root[k]),
        .prev_rad  (rad[k]),
        .prev_tag  (tag[k]),
        .vld       (vld[k+1]),
        .rem       (rem[k+1]),
        .root      (root[k+1]),
        .rad       (rad[k+1]),
        .tag       (tag[k+1])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sqrt_pipe.sv
// tb_sqrt_pipe: directed checks of sqrt_pipe at 32-bit and 8-bit
// radicand widths.
module tb_sqrt_pipe;
  import sqrt_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic busy8;

  sqrt_pipe_if #(.DATA_W(32), .TAG_W(4)) bus ();
  sqrt_pipe_if #(.DATA_W(8), .TAG_W(4)) bus8 ();

  sqrt_pipe #(.DATA_W(32), .TAG_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  sqrt_pipe #(.DATA_W(8), .TAG_W(4)) dut8 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus8),
    .busy (busy8)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] sb_x [$];
  logic [3:0]  sb_t [$];

  function automatic logic [15:0] ref_y(input logic [31:0] x);
    longint unsigned y, t;
    y = 0;
    for (int b = 15; b >= 0; b--) begin
      t = y | (64'd1 << b);
      if (t * t <= {32'd0, x}) y = t;
    end
    return y[15:0];
  endfunction

  function automatic logic [16:0] ref_rem(input logic [31:0] x);
    longint unsigned y, r;
    y = {48'd0, ref_y(x)};
    r = {32'd0, x} - y * y;
`ifdef SQRT_PIPE_REM_EN
    return r[16:0];
`else
    return (r == 0) ? 17'd0 : 17'd0;
`endif
  endfunction

  function automatic logic [16:0] rem_exp(input logic [16:0] r);
`ifdef SQRT_PIPE_REM_EN
    return r;
`else
    return (r == 0) ? 17'd0 : 17'd0;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.in_vld  = 1'b0;
    bus.in_x    = '0;
    bus.in_tag  = '0;
    bus.out_rdy = 1'b1;
    bus8.in_vld  = 1'b0;
    bus8.in_x    = '0;
    bus8.in_tag  = '0;
    bus8.out_rdy = 1'b1;
  endtask

  task automatic test_reset;
    idle();
    bus.out_rdy = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    n_chk++;
    if (bus.out_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_vld: got %b want 0", bus.out_vld);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    n_chk++;
    if (bus.out_y !== 16'd0 || bus.out_rem !== 17'd0 || bus.out_tag !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_data: got y=%0d rem=%0d tag=%0d want 0/0/0",
               bus.out_y, bus.out_rem, bus.out_tag);
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if (bus.in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_rdy: got %b want 1", bus.in_rdy);
    end
    bus.out_rdy = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] xv [4];
    logic [15:0] yv [4];
    logic [16:0] rv [4];
    int k;
    xv = '{32'd256, 32'd255, 32'd2147483648, 32'd4294967295};
    yv = '{16'd16, 16'd15, 16'd46340, 16'd65535};
    rv = '{17'd0, 17'd30, 17'd88048, 17'd131070};
    idle();
    for (int i = 0; i < 23; i++) begin
      k = i - 16;
      n_chk++;
      if (k >= 0 && k < 4) begin
        if (bus.out_vld !== 1'b1 || bus.out_y !== yv[k] ||
            bus.out_rem !== rem_exp(rv[k]) || bus.out_tag !== 4'(k)) begin
          n_fail++;
          $display("FAIL b2b_result[%0d]: got vld=%b y=%0d rem=%0d tag=%0d want 1/%0d/%0d/%0d",
                   k, bus.out_vld, bus.out_y, bus.out_rem, bus.out_tag,
                   yv[k], rem_exp(rv[k]), k);
        end
      end else if (bus.out_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_idle[%0d]: got out_vld=%b want 0", i, bus.out_vld);
      end
      if (i < 4) begin
        bus.in_vld = 1'b1;
        bus.in_x   = xv[i];
        bus.in_tag = 4'(i);
      end else begin
        bus.in_vld = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_zero_one;
    int k;
    idle();
    for (int i = 0; i < 20; i++) begin
      k = i - 16;
      if (k == 0 || k == 1) begin
        n_chk++;
        if (bus.out_vld !== 1'b1 || bus.out_y !== 16'(k) ||
            bus.out_rem !== 17'd0 || bus.out_tag !== 4'(5 + k)) begin
          n_fail++;
          $display("FAIL zero_one[%0d]: got vld=%b y=%0d rem=%0d tag=%0d want 1/%0d/0/%0d",
                   k, bus.out_vld, bus.out_y, bus.out_rem, bus.out_tag, k, 5 + k);
        end
      end
      if (i < 2) begin
        bus.in_vld = 1'b1;
        bus.in_x   = 32'(i);
        bus.in_tag = 4'(5 + i);
      end else begin
        bus.in_vld = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_random_stall;
    int sent, got, cyc;
    logic p_stall;
    logic [15:0] p_y;
    logic [16:0] p_rem;
    logic [3:0] p_tag;
    logic [31:0] xn;
    idle();
    sb_x.delete();
    sb_t.delete();
    sent = 0;
    got = 0;
    cyc = 0;
    p_stall = 1'b0;
    p_y = '0;
    p_rem = '0;
    p_tag = '0;
    while (got < 20 && cyc < 2000) begin
      if (p_stall) begin
        n_chk++;
        if (bus.out_vld !== 1'b1 || bus.out_y !== p_y ||
            bus.out_rem !== p_rem || bus.out_tag !== p_tag) begin
          n_fail++;
          $display("FAIL rand_stable: got vld=%b y=%0d rem=%0d tag=%0d want 1/%0d/%0d/%0d",
                   bus.out_vld, bus.out_y, bus.out_rem, bus.out_tag, p_y, p_rem, p_tag);
        end
      end
      bus.out_rdy = 1'($urandom_range(0, 1));
      if (sent < 20) begin
        xn = 32'(sent) * 32'h9E3779B1;
        xn = xn >> (4 * (sent % 8));
        bus.in_vld = ($urandom_range(0, 3) != 0);
        bus.in_x   = xn;
        bus.in_tag = 4'(sent);
      end else begin
        bus.in_vld = 1'b0;
      end
      #1;
      if (bus.out_vld && bus.out_rdy) begin
        n_chk++;
        if (sb_x.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra: got y=%0d with empty queue want none", bus.out_y);
        end else begin
          if (bus.out_y !== ref_y(sb_x[0]) || bus.out_rem !== ref_rem(sb_x[0]) ||
              bus.out_tag !== sb_t[0]) begin
            n_fail++;
            $display("FAIL rand_result[%0d]: got y=%0d rem=%0d tag=%0d want %0d/%0d/%0d",
                     got, bus.out_y, bus.out_rem, bus.out_tag,
                     ref_y(sb_x[0]), ref_rem(sb_x[0]), sb_t[0]);
          end
          void'(sb_x.pop_front());
          void'(sb_t.pop_front());
        end
        got++;
      end
      if (bus.in_vld && bus.in_rdy) begin
        sb_x.push_back(bus.in_x);
        sb_t.push_back(bus.in_tag);
        sent++;
      end
      p_stall = bus.out_vld && !bus.out_rdy;
      p_y = bus.out_y;
      p_rem = bus.out_rem;
      p_tag = bus.out_tag;
      tick();
      cyc++;
    end
    n_chk++;
    if (got != 20 || sb_x.size() != 0) begin
      n_fail++;
      $display("FAIL rand_count: got %0d results (%0d pending) want 20/0",
               got, sb_x.size());
    end
  endtask

  task automatic test_stall;
    int acc, cyc;
    logic [15:0] h_y;
    logic [16:0] h_rem;
    logic [3:0] h_tag;
    idle();
    sb_x.delete();
    sb_t.delete();
    bus.out_rdy = 1'b0;
    acc = 0;
    cyc = 0;
    while (!bus.out_vld && cyc < 100) begin
      bus.in_vld = 1'b1;
      bus.in_x   = 32'd1000 + 32'(acc) * 32'd7919003;
      bus.in_tag = 4'(acc);
      #1;
      if (bus.in_rdy) begin
        sb_x.push_back(bus.in_x);
        sb_t.push_back(bus.in_tag);
        acc++;
      end
      tick();
      cyc++;
    end
    n_chk++;
    if (bus.out_vld !== 1'b1 || acc != 16) begin
      n_fail++;
      $display("FAIL stall_fill: got vld=%b accepted=%0d want 1/16", bus.out_vld, acc);
    end
    h_y = bus.out_y;
    h_rem = bus.out_rem;
    h_tag = bus.out_tag;
    for (int i = 0; i < 10; i++) begin
      bus.in_vld = 1'b1;
      bus.in_x   = 32'hDEAD0000 + 32'(i);
      #1;
      n_chk++;
      if (bus.in_rdy !== 1'b0 || bus.out_vld !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got in_rdy=%b vld=%b busy=%b want 0/1/1",
                 i, bus.in_rdy, bus.out_vld, busy);
      end
      n_chk++;
      if (bus.out_y !== h_y || bus.out_rem !== h_rem || bus.out_tag !== h_tag) begin
        n_fail++;
        $display("FAIL stall_frozen[%0d]: got y=%0d rem=%0d tag=%0d want %0d/%0d/%0d",
                 i, bus.out_y, bus.out_rem, bus.out_tag, h_y, h_rem, h_tag);
      end
      tick();
    end
    bus.in_vld = 1'b0;
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_chk++;
      if (sb_x.size() == 0) begin
        n_fail++;
        $display("FAIL stall_drain[%0d]: got empty queue want entry", i);
      end else begin
        if (bus.out_vld !== 1'b1 || bus.out_y !== ref_y(sb_x[0]) ||
            bus.out_rem !== ref_rem(sb_x[0]) || bus.out_tag !== sb_t[0]) begin
          n_fail++;
          $display("FAIL stall_drain[%0d]: got vld=%b y=%0d rem=%0d tag=%0d want 1/%0d/%0d/%0d",
                   i, bus.out_vld, bus.out_y, bus.out_rem, bus.out_tag,
                   ref_y(sb_x[0]), ref_rem(sb_x[0]), sb_t[0]);
        end
        void'(sb_x.pop_front());
        void'(sb_t.pop_front());
      end
      tick();
    end
    n_chk++;
    if (bus.out_vld !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_empty: got vld=%b busy=%b want 0/0", bus.out_vld, busy);
    end
  endtask

  task automatic test_reset_flight;
    int seen;
    idle();
    for (int i = 0; i < 8; i++) begin
      bus.in_vld = 1'b1;
      bus.in_x   = 32'd12345 * 32'(i + 1);
      bus.in_tag = 4'(i);
      tick();
    end
    bus.in_vld = 1'b0;
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flight_busy: got %b want 1", busy);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (bus.out_vld !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flight_reset: got vld=%b busy=%b want 0/0", bus.out_vld, busy);
    end
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.out_vld === 1'b1) seen++;
      tick();
    end
    n_chk++;
    if (seen != 0 || bus.in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL flight_stale: got %0d results in_rdy=%b want 0/1", seen, bus.in_rdy);
    end
  endtask

  task automatic test_narrow;
    logic [7:0] xv [2];
    logic [3:0] yv [2];
    logic [4:0] rv [2];
    int k;
    xv = '{8'd255, 8'd200};
    yv = '{4'd15, 4'd14};
`ifdef SQRT_PIPE_REM_EN
    rv = '{5'd30, 5'd4};
`else
    rv = '{5'd0, 5'd0};
`endif
    idle();
    for (int i = 0; i < 8; i++) begin
      k = i - 4;
      n_chk++;
      if (k >= 0 && k < 2) begin
        if (bus8.out_vld !== 1'b1 || bus8.out_y !== yv[k] ||
            bus8.out_rem !== rv[k] || bus8.out_tag !== 4'(3 + k)) begin
          n_fail++;
          $display("FAIL narrow[%0d]: got vld=%b y=%0d rem=%0d tag=%0d want 1/%0d/%0d/%0d",
                   k, bus8.out_vld, bus8.out_y, bus8.out_rem, bus8.out_tag,
                   yv[k], rv[k], 3 + k);
        end
      end else if (bus8.out_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL narrow_idle[%0d]: got out_vld=%b want 0", i, bus8.out_vld);
      end
      if (i < 2) begin
        bus8.in_vld = 1'b1;
        bus8.in_x   = xv[i];
        bus8.in_tag = 4'(3 + i);
      end else begin
        bus8.in_vld = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_zero_one();
    test_random_stall();
    test_stall();
    test_reset_flight();
    test_narrow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sqrt_pipe.md
SQRT_PIPE -- requirements
Module: sqrt_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: radicand width; even, 4..64.
REQ-002 The block SHALL have parameter TAG_W, default 4: width of the user tag carried alongside each operand.
REQ-003 The block SHALL have derived localparam ROOT_W = DATA_W/2: root width and pipeline depth.
REQ-004 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-005 clk  in  1  clock; all state rises on posedge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 in_vld  in  1  operand valid.
REQ-008 in_rdy  out  1  block accepts operand this cycle.
REQ-009 in_x  in  DATA_W  unsigned radicand.
REQ-010 in_tag  in  TAG_W  user tag.
REQ-011 out_vld  out  1  result valid.
REQ-012 out_rdy  in  1  downstream accepts result.
REQ-013 out_y  out  ROOT_W  floor(sqrt(x)).
REQ-014 out_rem  out  ROOT_W+1  x - y*y.
REQ-015 out_tag  out  TAG_W  tag of the operand that produced the result.
REQ-016 busy  out  1  high when any pipeline stage holds a valid operand.

Function
REQ-017 The block SHALL compute the restoring digit-by-digit integer square root, one root bit per stage, MSB first, over ROOT_W registered stages.
REQ-018 Each stage SHALL hold a valid bit, partial remainder (ROOT_W+2 bits), partial root, remaining radicand bits and tag.
REQ-019 The advance signal SHALL be defined as adv = !out_vld | out_rdy; all stages SHALL shift only when adv=1, otherwise they hold.
REQ-020 in_rdy SHALL equal adv (combinational); an operand SHALL be accepted when in_vld & in_rdy.
REQ-021 With out_rdy held high, the result SHALL appear exactly ROOT_W cycles after acceptance; throughput SHALL be one result per cycle.
REQ-022 Bubbles SHALL NOT be compressed; an empty slot SHALL propagate as an empty slot.
REQ-023 out_y, out_rem and out_tag SHALL be stable while out_vld & !out_rdy.
REQ-024 Results SHALL leave in acceptance order; no result SHALL be dropped or duplicated under any out_rdy pattern.
REQ-025 Boundary values: x=0 gives y=0, rem=0; x=2^DATA_W-1 gives y=2^ROOT_W-1, rem=2^(ROOT_W+1)-2 with no overflow.
REQ-026 A simultaneous accept and emit with adv=1 SHALL both complete in the same cycle.
REQ-027 busy SHALL be the OR of all stage valid bits.

Reset
REQ-028 While rst=1, all stage valid bits SHALL clear immediately, so out_vld=0 and busy=0; in_rdy=1 after rst deasserts.
REQ-029 On reset, data registers SHALL clear to 0, so out_y=0, out_rem=0 and out_tag=0.
REQ-030 Reset mid-operation SHALL discard all in-flight operands; no stale result SHALL emerge afterwards.

Configuration
REQ-031 Macro SQRT_PIPE_REM_EN defined: remainder registers SHALL be built and out_rem SHALL carry x - y*y.
REQ-032 Macro SQRT_PIPE_REM_EN undefined: out_rem SHALL remain a port tied to 0, and final-stage remainder storage SHALL be removed; the port list SHALL be unchanged.

Structure
REQ-033 Package sqrt_pkg SHALL hold the default width constants and a stage-record typedef (valid, rem, root, radicand, tag), parametrised via localparams.
REQ-034 The block SHALL use a single sub-module, sqrt_stage: one combinational trial-subtract of one root bit plus its registers, instantiated ROOT_W times via generate.

Verification
REQ-035 Scenario: DATA_W=32, out_rdy=1, back-to-back x=256,255,2147483648,4294967295 -> y=16/15/46340/65535, rem=0/30/88048/131070, 16 cycles after each accept.
REQ-036 Scenario: x=0 then 1 -> y=0, rem=0; then y=1, rem=0.
REQ-037 Scenario: stream of 20 operands with out_rdy toggling pseudo-randomly -> every result matches a reference model in order, tags intact, out_* stable while stalled.
REQ-038 Scenario: fill the pipe, hold out_rdy=0 for 10 cycles -> in_rdy=0 and outputs frozen; release -> results resume one per cycle.
REQ-039 Scenario: assert rst with 8 operands in flight -> out_vld=0 and busy=0 immediately, and no result appears afterwards.
REQ-040 Scenario: DATA_W=8, x=255 -> y=15 after 4 cycles; rem=30 with SQRT_PIPE_REM_EN defined, rem=0 without it.
